// File: rtl/tag_verification.sv
// rtl/tag_verification.sv - keyed 8-bit tag checker with two-stage result pipeline
// Optional lockout FSM enabled by defining TAG_VERIFY_LOCKOUT_EN.
module tag_verification #(
   parameter int          DATA_SIZE  = 32,
   parameter int          TAG_SIZE   = 8,
   parameter logic [15:0] SECRET_KEY = 16'hDEAD,
   parameter int          MAX_FAILS  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_SIZE-1:0] data,
   input  logic [TAG_SIZE-1:0]  tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 tag_ok,
   output logic [TAG_SIZE-1:0]  calc_tag,
   output logic [15:0]          fail_count,
   output logic                 locked,
   input  logic                 unlock
);

   function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] s);
      logic [15:0] d;
      d = {v, v} << s;
      return d[15:8];
   endfunction

   // Each byte is optionally inverted by key bit i, then rotated by the low 3 bits of key nibble i.
   function automatic logic [7:0] compute_tag(input logic [31:0] w);
      logic [7:0] acc;
      logic [7:0] f;
      acc = 8'h00;
      for (int i = 0; i < 4; i++) begin
         f   = SECRET_KEY[i] ? ~w[8*i +: 8] : w[8*i +: 8];
         acc = acc ^ rotl8(f, SECRET_KEY[4*i +: 3]);
      end
      return acc;
   endfunction

   logic       s1_valid;
   logic [7:0] s1_calc;
   logic [7:0] s1_tag;
   logic       s2_valid;
   logic       accept;
   logic       s1_move;
   logic       mismatch;

   assign out_valid = s2_valid;
   assign in_ready  = !reset && !locked && (!s1_valid || !s2_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign s1_move   = s1_valid && (!s2_valid || out_ready);
   assign mismatch  = s1_calc != s1_tag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_calc    <= 8'h00;
         s1_tag     <= 8'h00;
         s2_valid   <= 1'b0;
         tag_ok     <= 1'b0;
         calc_tag   <= 8'h00;
         fail_count <= 16'h0000;
      end else begin
         if (accept) begin
            s1_calc <= compute_tag(data);
            s1_tag  <= tag;
         end
         s1_valid <= accept || (s1_valid && !s1_move);
         // Statistics are taken when a result enters S2, independent of when it is consumed.
         if (s1_move) begin
            tag_ok   <= !mismatch;
            calc_tag <= s1_calc;
            if (mismatch && fail_count != 16'hFFFF)
               fail_count <= fail_count + 16'd1;
         end
         s2_valid <= s1_move || (s2_valid && !out_ready);
      end
   end

`ifdef TAG_VERIFY_LOCKOUT_EN
   localparam logic [0:0] ST_OPEN   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;
   localparam logic [3:0] FAIL_LIMIT = 4'(MAX_FAILS);

   logic [0:0] state;
   logic [3:0] consec_fail;
   logic [3:0] consec_inc;

   assign consec_inc = (consec_fail == 4'hF) ? 4'hF : consec_fail + 4'd1;
   assign locked     = (state == ST_LOCKED);

   // unlock has priority over a mismatch arriving in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_OPEN;
         consec_fail <= 4'h0;
      end else if (unlock) begin
         state       <= ST_OPEN;
         consec_fail <= 4'h0;
      end else if (s1_move) begin
         if (mismatch) begin
            consec_fail <= consec_inc;
            if (consec_inc >= FAIL_LIMIT)
               state <= ST_LOCKED;
         end else begin
            consec_fail <= 4'h0;
         end
      end
   end
`else
   logic unused_unlock;
   assign unused_unlock = unlock;
   assign locked        = 1'b0;
`endif

endmodule

// File: tb/tb_tag_verification.sv
// tb/tb_tag_verification.sv - directed self-checking bench for tag_verification
module tb_tag_verification;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data;
   logic [7:0]  tag;
   logic        out_valid;
   logic        out_ready;
   logic        tag_ok;
   logic [7:0]  calc_tag;
   logic [15:0] fail_count;
   logic        locked;
   logic        unlock;

   int vectors    = 0;
   int miscompares = 0;

   logic [31:0] s_data [8] = '{32'h0000_0001, 32'h0000_0200, 32'h0003_0000, 32'h0400_0000,
                               32'h0000_00FF, 32'h1234_5678, 32'h8000_0000, 32'h0000_1000};
   logic [7:0]  s_tag  [8] = '{8'hDF, 8'hF6, 8'h3F, 8'h00, 8'h01, 8'hE6, 8'hEF, 8'hBE};
   logic [7:0]  s_calc [8] = '{8'hDF, 8'hF7, 8'h3F, 8'h7F, 8'h00, 8'hE6, 8'hEF, 8'hBF};
   logic        s_ok   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   tag_verification dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data       (data),
      .tag        (tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .tag_ok     (tag_ok),
      .calc_tag   (calc_tag),
      .fail_count (fail_count),
      .locked     (locked),
      .unlock     (unlock)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic send_one(input logic [31:0] d, input logic [7:0] t,
                           output logic o_ok, output logic [7:0] o_calc);
      int n;
      @(negedge clk);
      data = d; tag = t; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      check("send_result_valid", out_valid, 1);
      o_ok   = tag_ok;
      o_calc = calc_tag;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ok;
      logic [7:0] c;
      int tx, rx, cyc;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; unlock = 1'b0;
      data = 32'h0; tag = 8'h0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_calc_tag", calc_tag, 8'h00);
      check("rst_fail_count", fail_count, 0);
      check("rst_locked", locked, 0);

      // 1: latency and all-zero word
      @(negedge clk);
      reset = 1'b0; data = 32'h0; tag = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
      #1 check("t1_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("t1_out_valid_early", out_valid, 0);
      @(negedge clk);
      check("t1_out_valid", out_valid, 1);
      check("t1_tag_ok", tag_ok, 1);
      check("t1_calc_tag", calc_tag, 8'hFF);

      // 2: single-byte word, good then bad tag
      send_one(32'h0000_0100, 8'hFB, ok, c);
      check("t2_ok_good", ok, 1);
      check("t2_calc", c, 8'hFB);
      send_one(32'h0000_0100, 8'hFA, ok, c);
      check("t2_ok_bad", ok, 0);
      check("t2_fail_count", fail_count, 1);

      // 3: back-to-back stream with a 3-cycle consumer stall
      tx = 0; rx = 0; cyc = 0;
      while (rx < 8 && cyc < 40) begin
         @(negedge clk);
         out_ready = !(cyc >= 4 && cyc <= 6);
         in_valid  = (tx < 8);
         if (tx < 8) begin data = s_data[tx]; tag = s_tag[tx]; end
         #1;
         if (cyc >= 4 && cyc <= 6) check("t3_stall_in_ready", in_ready, 0);
         if (out_valid && out_ready) begin
            check($sformatf("t3_calc_%0d", rx), calc_tag, s_calc[rx]);
            check($sformatf("t3_ok_%0d", rx), tag_ok, s_ok[rx]);
            rx++;
         end
         if (in_valid && in_ready) tx++;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("t3_results", rx, 8);
      check("t3_fail_count", fail_count, 5);

`ifdef TAG_VERIFY_LOCKOUT_EN
      // 4: three bad then good -> no lock; four bad -> lock; unlock releases
      send_one(32'h0, 8'hFF, ok, c);
      for (int i = 0; i < 3; i++) send_one(32'h0, 8'h00, ok, c);
      check("t4_no_lock_3bad", locked, 0);
      send_one(32'h0, 8'hFF, ok, c);
      check("t4_no_lock_good", locked, 0);
      for (int i = 0; i < 4; i++) send_one(32'h0, 8'h00, ok, c);
      check("t4_locked", locked, 1);
      check("t4_locked_in_ready", in_ready, 0);
      @(negedge clk);
      in_valid = 1'b1; data = 32'h0; tag = 8'hFF;
      repeat (3) @(negedge clk);
      check("t4_locked_blocks", in_ready, 0);
      check("t4_locked_no_out", out_valid, 0);
      in_valid = 1'b0;
      unlock = 1'b1;
      @(negedge clk);
      unlock = 1'b0;
      check("t4_unlocked", locked, 0);
      check("t4_unlock_in_ready", in_ready, 1);
      check("t4_fail_count", fail_count, 12);
`else
      // 5: no lockout build never locks
      for (int i = 0; i < 20; i++) begin
         send_one(32'h0, 8'h00, ok, c);
         check("t5_locked", locked, 0);
      end
      check("t5_fail_count", fail_count, 25);
`endif

      // 6: reset with two words in flight
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; data = 32'h0; tag = 8'hFF;
      @(negedge clk);
      data = 32'h0000_0100; tag = 8'hFA;
      @(negedge clk);
      in_valid = 1'b0;
      check("t6_in_flight", out_valid, 1);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_out_valid", out_valid, 0);
      check("t6_rst_in_ready", in_ready, 0);
      check("t6_rst_fail_count", fail_count, 0);
      check("t6_rst_tag_ok", tag_ok, 0);
      check("t6_rst_calc_tag", calc_tag, 8'h00);
      check("t6_rst_locked", locked, 0);
      @(negedge clk);
      reset = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t6_no_stale", out_valid, 0);
      end
      check("t6_post_in_ready", in_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
